// File: rtl/mac_sequencer.sv
// mac_sequencer
//   Serial dot-product controller. Accepts one unsigned (x,w) pair per
//   valid/ready handshake, multiplies it on a single shared multiplier and
//   folds it into an accumulator. After N_TERMS pairs the low DATA_W bits of
//   the sum are presented on result until the consumer takes them.
//
//   Optional feature macro: MAC_SEQ_SATURATE_EN
//     defined   - accumulator is ACC_W+8 bits wide (no wrap) and result
//                 saturates to all-ones when the sum exceeds 2^DATA_W-1.
//     undefined - accumulator wraps mod 2^ACC_W, result = acc[DATA_W-1:0],
//                 bit-identical to the parallel multiplier tree.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (priority over clear)
//   clear      synchronous abort of the current dot product
//   in_valid   x_in/w_in hold a valid pair
//   in_ready   sequencer will take a pair this cycle (low only in DONE)
//   x_in,w_in  unsigned operands
//   out_valid  result valid (held until out_ready)
//   out_ready  consumer takes result this cycle
//   result     dot-product result, holds its value across clear
//   busy       a dot product is in progress (ACCUM or DONE)
//   term_cnt   pairs accepted in the current dot product
module mac_sequencer #(
  parameter int N_TERMS = 8,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] w_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              busy,
  output logic [7:0]        term_cnt
);

`ifdef MAC_SEQ_SATURATE_EN
  localparam int AW = ACC_W + 8;
`else
  localparam int AW = ACC_W;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [7:0] LAST_CNT = 8'(N_TERMS);

  logic [1:0]          state;
  logic [AW-1:0]       acc;
  logic [2*DATA_W-1:0] prod;
  logic [AW-1:0]       prod_ext;
  logic [AW-1:0]       acc_sum;
  logic [7:0]          cnt_nxt;
  logic                accept;

  // Full-width unsigned product, zero-extended into the accumulator width.
  assign prod     = {{DATA_W{1'b0}}, x_in} * {{DATA_W{1'b0}}, w_in};
  assign prod_ext = AW'(prod);
  assign acc_sum  = acc + prod_ext;
  assign cnt_nxt  = term_cnt + 8'd1;

  assign in_ready = (state != S_DONE);
  assign accept   = in_valid & in_ready;
  assign busy     = (state != S_IDLE);

  // Map a final accumulator value to the presented result.
  function automatic logic [DATA_W-1:0] res_of(input logic [AW-1:0] a);
`ifdef MAC_SEQ_SATURATE_EN
    if (|a[AW-1:DATA_W]) return {DATA_W{1'b1}};
    else                 return a[DATA_W-1:0];
`else
    return a[DATA_W-1:0];
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      term_cnt  <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      // Abort wins over any accept or output handshake this cycle; the last
      // presented result is kept for observability.
      state     <= S_IDLE;
      acc       <= '0;
      term_cnt  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            // First term overwrites the accumulator rather than adding.
            acc      <= prod_ext;
            term_cnt <= 8'd1;
            if (N_TERMS == 1) begin
              state     <= S_DONE;
              result    <= res_of(prod_ext);
              out_valid <= 1'b1;
            end else begin
              state <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (accept) begin
            acc      <= acc_sum;
            term_cnt <= cnt_nxt;
            // Result is captured from the sum including the final product,
            // so out_valid rises the cycle after the last accept.
            if (cnt_nxt == LAST_CNT) begin
              state     <= S_DONE;
              result    <= res_of(acc_sum);
              out_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          // in_ready is low here, so a pair offered alongside the output
          // handshake waits for IDLE.
          if (out_ready) begin
            state     <= S_IDLE;
            term_cnt  <= '0;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          acc       <= '0;
          term_cnt  <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
module tb_mac_sequencer;
  logic       clk = 1'b0;
  logic       rst, clear, in_valid, out_ready;
  logic [7:0] x_in, w_in;
  logic       in_ready, out_valid, busy;
  logic [7:0] result, term_cnt;

  // Single-term instance
  logic       clear1, in_valid1, out_ready1;
  logic [7:0] x1, w1;
  logic       in_ready1, out_valid1, busy1;
  logic [7:0] result1, term_cnt1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mac_sequencer #(.N_TERMS(8), .DATA_W(8), .ACC_W(16)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .w_in(w_in), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy), .term_cnt(term_cnt)
  );

  mac_sequencer #(.N_TERMS(1), .DATA_W(8), .ACC_W(16)) dut1 (
    .clk(clk), .rst(rst), .clear(clear1), .in_valid(in_valid1), .in_ready(in_ready1),
    .x_in(x1), .w_in(w1), .out_valid(out_valid1), .out_ready(out_ready1),
    .result(result1), .busy(busy1), .term_cnt(term_cnt1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one pair for exactly one cycle (caller ensures in_ready=1).
  task automatic send(input logic [7:0] x, input logic [7:0] w);
    x_in = x; w_in = w; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    x_in = 8'd5; w_in = 8'd5;
    clear1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; x1 = 8'd0; w1 = 8'd0;
    repeat (3) tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests++; if (result !== 8'h00) begin fails++; $display("FAIL reset_result got %h exp 00", result); end
    tests++; if (term_cnt !== 8'd0) begin fails++; $display("FAIL reset_term_cnt got %0d exp 0 (in_valid ignored in reset)", term_cnt); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_ones();
    x_in = 8'd1; w_in = 8'd1; in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ones_early_valid before accept %0d got %b exp 0", i, out_valid); end
      tick();
      tests++; if (term_cnt !== 8'(i)) begin fails++; $display("FAIL ones_term_cnt got %0d exp %0d", term_cnt, i); end
    end
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL ones_out_valid got %b exp 1", out_valid); end
    tests++; if (result !== 8'h08) begin fails++; $display("FAIL ones_result got %h exp 08", result); end
    tests++; if (in_ready !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL ones_done_flags got ready=%b busy=%b exp 0 1", in_ready, busy); end
    handshake();
    tests++; if (out_valid !== 1'b0 || term_cnt !== 8'd0 || busy !== 1'b0) begin
      fails++; $display("FAIL ones_after_hs got v=%b cnt=%0d busy=%b exp 0 0 0", out_valid, term_cnt, busy); end
  endtask

  task automatic test_gaps();
    int gaps [8] = '{0, 2, 1, 3, 0, 1, 2, 3};
    for (int i = 0; i < 8; i++) begin
      repeat (gaps[i]) tick();
      tests++; if (term_cnt !== 8'(i)) begin fails++; $display("FAIL gaps_hold got %0d exp %0d", term_cnt, i); end
      send(8'(i + 1), 8'd2);
      tests++; if (term_cnt !== 8'(i + 1)) begin fails++; $display("FAIL gaps_term_cnt got %0d exp %0d", term_cnt, i + 1); end
    end
    tests++; if (out_valid !== 1'b1 || result !== 8'h48) begin
      fails++; $display("FAIL gaps_result got v=%b r=%h exp 1 48", out_valid, result); end
    handshake();
  endtask

  task automatic test_max();
    for (int i = 0; i < 8; i++) send(8'hFF, 8'hFF);
`ifdef MAC_SEQ_SATURATE_EN
    tests++; if (result !== 8'hFF) begin fails++; $display("FAIL max_result got %h exp FF", result); end
`else
    tests++; if (result !== 8'h08) begin fails++; $display("FAIL max_result got %h exp 08", result); end
`endif
    handshake();
  endtask

  task automatic test_back_to_back();
    x_in = 8'd3; w_in = 8'd1; in_valid = 1'b1;
    repeat (8) tick();
    x_in = 8'd5; w_in = 8'd5;   // next pair offered while DONE
    for (int i = 0; i < 5; i++) begin
      tests++; if (out_valid !== 1'b1 || result !== 8'h18 || in_ready !== 1'b0 || term_cnt !== 8'd8) begin
        fails++; $display("FAIL b2b_stall got v=%b r=%h rdy=%b cnt=%0d exp 1 18 0 8", out_valid, result, in_ready, term_cnt); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || term_cnt !== 8'd0) begin
      fails++; $display("FAIL b2b_hs got v=%b rdy=%b cnt=%0d exp 0 1 0", out_valid, in_ready, term_cnt); end
    tick();
    tests++; if (term_cnt !== 8'd1) begin fails++; $display("FAIL b2b_next_accept got %0d exp 1", term_cnt); end
    repeat (7) tick();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || result !== 8'hC8) begin
      fails++; $display("FAIL b2b_result got v=%b r=%h exp 1 C8", out_valid, result); end
    handshake();
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) send(8'd9, 8'd9);
    tests++; if (term_cnt !== 8'd3) begin fails++; $display("FAIL clr_pre_cnt got %0d exp 3", term_cnt); end
    clear = 1'b1; x_in = 8'd9; w_in = 8'd9; in_valid = 1'b1;  // clear beats accept
    tick();
    clear = 1'b0; in_valid = 1'b0;
    tests++; if (term_cnt !== 8'd0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL clr_state got cnt=%0d busy=%b v=%b exp 0 0 0", term_cnt, busy, out_valid); end
    for (int i = 0; i < 8; i++) send(8'd2, 8'd3);
    tests++; if (out_valid !== 1'b1 || result !== 8'h30) begin
      fails++; $display("FAIL clr_result got v=%b r=%h exp 1 30", out_valid, result); end
    clear = 1'b1; out_ready = 1'b1;  // clear beats output handshake
    tick();
    clear = 1'b0; out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0 || result !== 8'h30 || busy !== 1'b0) begin
      fails++; $display("FAIL clr_done got v=%b r=%h busy=%b exp 0 30 0", out_valid, result, busy); end
    for (int i = 0; i < 5; i++) send(8'd4, 8'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (out_valid !== 1'b0 || result !== 8'h00 || term_cnt !== 8'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL rst_mid got v=%b r=%h cnt=%0d busy=%b rdy=%b exp 0 00 0 0 1",
                        out_valid, result, term_cnt, busy, in_ready); end
    for (int i = 0; i < 8; i++) send(8'd1, 8'd1);
    tests++; if (result !== 8'h08) begin fails++; $display("FAIL rst_no_stale got %h exp 08", result); end
    handshake();
  endtask

  task automatic test_single_term();
    x1 = 8'd7; w1 = 8'd9; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    tests++; if (out_valid1 !== 1'b1 || result1 !== 8'h3F || term_cnt1 !== 8'd1 || in_ready1 !== 1'b0) begin
      fails++; $display("FAIL n1_done got v=%b r=%h cnt=%0d rdy=%b exp 1 3F 1 0", out_valid1, result1, term_cnt1, in_ready1); end
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    tests++; if (out_valid1 !== 1'b0 || busy1 !== 1'b0 || result1 !== 8'h3F) begin
      fails++; $display("FAIL n1_hs got v=%b busy=%b r=%h exp 0 0 3F", out_valid1, busy1, result1); end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_gaps();
    test_max();
    test_back_to_back();
    test_clear();
    test_single_term();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
